// File: rtl/long_lat_scoreboard_if.sv
// long_lat_scoreboard_if: decode-stage query, issue and writeback bundle for the scoreboard
//   q_vld/q_rs1/q_rs2/q_rd/q_rs1_vld/q_rs2_vld/q_wr_en/q_long : D-stage instruction under check
//   iss_vld : D instruction leaves D this cycle
//   cmp_vld/cmp_rd : long-latency writeback
//   stall : combinational hazard stall, pending : per-register pending writes
//   outst_cnt : in-flight long ops, err : sticky protocol error
interface long_lat_scoreboard_if #(parameter int NUM_REGS = 32);
   logic                q_vld;
   logic [4:0]          q_rs1;
   logic [4:0]          q_rs2;
   logic [4:0]          q_rd;
   logic                q_rs1_vld;
   logic                q_rs2_vld;
   logic                q_wr_en;
   logic                q_long;
   logic                iss_vld;
   logic                cmp_vld;
   logic [4:0]          cmp_rd;
   logic                stall;
   logic [NUM_REGS-1:0] pending;
   logic [1:0]          outst_cnt;
   logic                err;
   modport master (
      output q_vld, q_rs1, q_rs2, q_rd, q_rs1_vld, q_rs2_vld, q_wr_en, q_long, iss_vld, cmp_vld, cmp_rd,
      input  stall, pending, outst_cnt, err
   );
   modport slave (
      input  q_vld, q_rs1, q_rs2, q_rd, q_rs1_vld, q_rs2_vld, q_wr_en, q_long, iss_vld, cmp_vld, cmp_rd,
      output stall, pending, outst_cnt, err
   );
endinterface

// File: rtl/long_lat_scoreboard.sv
// long_lat_scoreboard: pending-write scoreboard and in-flight counter for long-latency ops
//   clk : clock, rst : synchronous active-high reset
//   sb  : slave side of long_lat_scoreboard_if (query/issue/completion in, stall/pending/outst_cnt/err out)
module long_lat_scoreboard #(
   parameter int NUM_REGS  = 32,
   parameter int MAX_OUTST = 2
) (
   input logic                   clk,
   input logic                   rst,
   long_lat_scoreboard_if.slave  sb
);
   localparam int RF_IDX_WIDTH = 5;
   localparam logic [1:0] MAX = 2'(MAX_OUTST);
   logic [NUM_REGS-1:0] pend_q, pend_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                il, set, clr, pend1, pend2, raw, waw, strct;
   always_comb begin
      il  = sb.iss_vld && sb.q_long;
      set = il && sb.q_wr_en && sb.q_rd != '0;
      clr = sb.cmp_vld && sb.cmp_rd != '0;
      pend_d = pend_q;
      if (clr) pend_d[sb.cmp_rd] = 1'b0;
      // set applied after clear so a same-edge issue to the completing rd stays pending
      if (set) pend_d[sb.q_rd] = 1'b1;
      pend_d[0] = 1'b0;
      // simultaneous issue and completion leave the count alone
      cnt_d = (il && !sb.cmp_vld && cnt_q != MAX) ? cnt_q + 2'd1 :
              (sb.cmp_vld && !il && cnt_q != 2'd0) ? cnt_q - 2'd1 : cnt_q;
      err_d = err_q
            || (clr && !pend_q[sb.cmp_rd])
            || (sb.cmp_vld && cnt_q == 2'd0)
            || (il && cnt_q == MAX && !sb.cmp_vld);
      // a completion this cycle releases the hazard on its rd
      pend1 = pend_q[sb.q_rs1] && !(sb.cmp_vld && sb.cmp_rd == sb.q_rs1);
      pend2 = pend_q[sb.q_rs2] && !(sb.cmp_vld && sb.cmp_rd == sb.q_rs2);
      raw   = (sb.q_rs1_vld && sb.q_rs1 != '0 && pend1) || (sb.q_rs2_vld && sb.q_rs2 != '0 && pend2);
      waw   = sb.q_wr_en && sb.q_rd != '0 && pend_q[sb.q_rd] && !(sb.cmp_vld && sb.cmp_rd == sb.q_rd);
      strct = sb.q_long && cnt_q == MAX && !sb.cmp_vld;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
         cnt_q  <= 2'd0;
         err_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end
   logic [RF_IDX_WIDTH-1:0] unused_idx;
   assign unused_idx   = '0;
   assign sb.stall     = sb.q_vld && (raw || waw || strct);
   assign sb.pending   = pend_q;
   assign sb.outst_cnt = cnt_q;
   assign sb.err       = err_q;
endmodule

// File: tb/tb_long_lat_scoreboard.sv
// tb_long_lat_scoreboard: directed and random checks of long_lat_scoreboard against a queue-free array model
module tb_long_lat_scoreboard;
   localparam int MAXO = 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   bit   mpend [32];
   int   mcnt;
   bit   merr;
   always #5 clk = ~clk;
   long_lat_scoreboard_if #(.NUM_REGS(32)) bus ();
   long_lat_scoreboard #(.NUM_REGS(32), .MAX_OUTST(MAXO)) dut (.clk(clk), .rst(rst), .sb(bus));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [4:0] r1, input logic r1v, input logic [4:0] r2,
                        input logic r2v, input logic [4:0] d, input logic w, input logic l,
                        input logic is, input logic cv, input logic [4:0] cr);
      bus.q_vld = v; bus.q_rs1 = r1; bus.q_rs1_vld = r1v; bus.q_rs2 = r2; bus.q_rs2_vld = r2v;
      bus.q_rd = d; bus.q_wr_en = w; bus.q_long = l; bus.iss_vld = is; bus.cmp_vld = cv; bus.cmp_rd = cr;
   endtask
   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   function automatic bit busy(input logic [4:0] r);
      return r != 0 && mpend[r] && !(bus.cmp_vld && bus.cmp_rd == r);
   endfunction
   function automatic bit mstall();
      bit raw, waw, st;
      raw = (bus.q_rs1_vld && busy(bus.q_rs1)) || (bus.q_rs2_vld && busy(bus.q_rs2));
      waw = bus.q_wr_en && busy(bus.q_rd);
      st  = bus.q_long && mcnt == MAXO && !bus.cmp_vld;
      return bus.q_vld && (raw || waw || st);
   endfunction
   function automatic logic [31:0] mvec();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = mpend[i];
      return v;
   endfunction
   task automatic look();
      @(negedge clk);
      chk("model_stall", {31'b0, bus.stall}, {31'b0, mstall()});
      chk("model_pending", bus.pending, mvec());
      chk("model_cnt", {30'b0, bus.outst_cnt}, 32'(mcnt));
      chk("model_err", {31'b0, bus.err}, {31'b0, merr});
   endtask
   task automatic adv();
      bit il;
      int n;
      @(posedge clk);
      il = bus.iss_vld && bus.q_long;
      if (rst) begin
         for (int i = 0; i < 32; i++) mpend[i] = 0;
         mcnt = 0;
         merr = 0;
      end else begin
         if (bus.cmp_vld && ((bus.cmp_rd != 0 && !mpend[bus.cmp_rd]) || mcnt == 0)) merr = 1;
         if (il && mcnt == MAXO && !bus.cmp_vld) merr = 1;
         if (bus.cmp_vld && bus.cmp_rd != 0) mpend[bus.cmp_rd] = 0;
         if (il && bus.q_wr_en && bus.q_rd != 0) mpend[bus.q_rd] = 1;
         n = mcnt + (il ? 1 : 0) - (bus.cmp_vld ? 1 : 0);
         mcnt = n < 0 ? 0 : n > MAXO ? MAXO : n;
      end
      #1;
   endtask
   task automatic step();
      look();
      adv();
   endtask
   initial begin
      logic [4:0] cr;
      mcnt = 0;
      merr = 0;
      idle();
      #1;
      adv();
      rst = 1'b0;
      idle(); look();
      chk("rst_pending", bus.pending, 32'h0);
      chk("rst_cnt", {30'b0, bus.outst_cnt}, 32'd0);
      chk("rst_err", {31'b0, bus.err}, 32'd0);
      adv();
      drive(1, 0, 0, 0, 0, 5, 1, 1, 1, 0, 0); step();
      drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); look();
      chk("lu_stall", {31'b0, bus.stall}, 32'd1);
      chk("lu_pend5", {31'b0, bus.pending[5]}, 32'd1);
      adv();
      drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 5); look();
      chk("lu_bypass", {31'b0, bus.stall}, 32'd0);
      adv();
      idle(); look();
      chk("lu_clear", {31'b0, bus.pending[5]}, 32'd0);
      adv();
      drive(1, 0, 0, 0, 0, 3, 1, 1, 1, 0, 0); step();
      drive(1, 0, 0, 0, 0, 4, 1, 1, 1, 0, 0); step();
      drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0); look();
      chk("st_stall", {31'b0, bus.stall}, 32'd1);
      chk("st_cnt", {30'b0, bus.outst_cnt}, 32'd2);
      adv();
      drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 1, 3); look();
      chk("st_release", {31'b0, bus.stall}, 32'd0);
      adv();
      idle(); look();
      chk("st_cnt1", {30'b0, bus.outst_cnt}, 32'd1);
      adv();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4); step();
      drive(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0); step();
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); look();
      chk("x0_pending", bus.pending, 32'h0);
      chk("x0_cnt", {30'b0, bus.outst_cnt}, 32'd1);
      chk("x0_stall", {31'b0, bus.stall}, 32'd0);
      adv();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step();
      idle(); look();
      chk("x0_cnt0", {30'b0, bus.outst_cnt}, 32'd0);
      chk("x0_err", {31'b0, bus.err}, 32'd0);
      adv();
      drive(1, 0, 0, 0, 0, 7, 1, 1, 1, 0, 0); step();
      drive(1, 0, 0, 0, 0, 7, 1, 1, 1, 1, 7); step();
      idle(); look();
      chk("se_pend7", {31'b0, bus.pending[7]}, 32'd1);
      chk("se_cnt", {30'b0, bus.outst_cnt}, 32'd1);
      chk("se_err", {31'b0, bus.err}, 32'd0);
      adv();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7); step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9); step();
      idle(); look();
      chk("er_set", {31'b0, bus.err}, 32'd1);
      adv();
      idle(); look();
      chk("er_hold", {31'b0, bus.err}, 32'd1);
      adv();
      drive(1, 0, 0, 0, 0, 10, 1, 1, 1, 0, 0); step();
      drive(1, 0, 0, 0, 0, 11, 1, 1, 1, 0, 0); step();
      rst = 1'b1;
      drive(1, 0, 0, 0, 0, 12, 1, 1, 1, 1, 10); adv();
      rst = 1'b0;
      idle(); look();
      chk("rr_pending", bus.pending, 32'h0);
      chk("rr_cnt", {30'b0, bus.outst_cnt}, 32'd0);
      chk("rr_err", {31'b0, bus.err}, 32'd0);
      adv();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10); step();
      idle(); look();
      chk("rr_stale_err", {31'b0, bus.err}, 32'd1);
      adv();
      for (int k = 0; k < 600; k++) begin
         rst = ($urandom_range(0, 39) == 0);
         drive($urandom_range(0, 3) != 0, 5'($urandom), $urandom_range(0, 1) == 1, 5'($urandom),
               $urandom_range(0, 1) == 1, 5'($urandom), $urandom_range(0, 3) != 0,
               $urandom_range(0, 1) == 1, 0, 0, 0);
         cr = 5'($urandom);
         for (int t = 0; t < 12 && !mpend[cr]; t++) cr = 5'($urandom);
         bus.cmp_vld = mcnt > 0 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 15) == 0;
         bus.cmp_rd  = $urandom_range(0, 9) == 0 ? 5'd0 : cr;
         bus.iss_vld = bus.q_vld && (!mstall() || $urandom_range(0, 15) == 0) && $urandom_range(0, 1) == 1;
         step();
      end
      rst = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/long_lat_scoreboard.md
LONG_LAT_SCOREBOARD -- requirements
Module: long_lat_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 32: number of architectural registers tracked; index width RF_IDX_WIDTH = 5.
REQ-002 Parameter MAX_OUTST, default 2: maximum in-flight long-latency ops (loads, iterative mul/div); 1..3.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 q_vld  in  1  D stage holds a valid instruction being checked this cycle.
REQ-006 q_rs1, q_rs2, q_rd  in  5 each  source and destination indices of the D instruction.
REQ-007 q_rs1_vld, q_rs2_vld, q_wr_en  in  1 each  operand-used and writeback flags of the D instruction.
REQ-008 q_long  in  1  D instruction is long-latency (load or mul/div).
REQ-009 iss_vld  in  1  D instruction leaves D this cycle, not stalled and not squashed.
REQ-010 cmp_vld  in  1  long-latency result written back this cycle.
REQ-011 cmp_rd  in  5  destination of the completing result.
REQ-012 stall  out  1  combinational hazard stall for D.
REQ-013 pending  out  NUM_REGS  registered per-register pending-write vector.
REQ-014 outst_cnt  out  2  registered in-flight long-op count.
REQ-015 err  out  1  sticky protocol-error flag.

Function
REQ-016 The block SHALL set pending[q_rd] at the clock edge when iss_vld && q_long && q_wr_en && q_rd != 0.
REQ-017 The block SHALL clear pending[cmp_rd] at the clock edge when cmp_vld && cmp_rd != 0.
REQ-018 pending[0] SHALL be 0 at all times.
REQ-019 Same-edge issue and completion to the same rd: the set SHALL win, and pending stays 1.
REQ-020 outst_cnt SHALL increment on iss_vld && q_long and decrement on cmp_vld.
REQ-021 When both occur in the same cycle, outst_cnt SHALL be unchanged.
REQ-022 outst_cnt SHALL saturate at 0 and at MAX_OUTST; it never wraps.
REQ-023 stall SHALL equal q_vld && (RAW || WAW || STRUCT), using only registered state plus the current cmp bypass:
  - RAW: (q_rs1_vld && q_rs1 != 0 && pend1) || (q_rs2_vld && q_rs2 != 0 && pend2).
  - pendN = pending[q_rsN] && !(cmp_vld && cmp_rd == q_rsN), i.e. a completion in the same cycle releases the stall.
  - WAW: q_wr_en && q_rd != 0 && pending[q_rd] && !(cmp_vld && cmp_rd == q_rd).
  - STRUCT: q_long && outst_cnt == MAX_OUTST && !cmp_vld.
REQ-024 stall SHALL be 0 whenever q_vld == 0.
REQ-025 Squashed instructions are never presented with iss_vld, so a squash SHALL have no effect on scoreboard state.
REQ-026 In-flight long ops SHALL remain tracked across squashes until completion.
REQ-027 err SHALL set, and stay set until reset, on any of:
  - cmp_vld with cmp_rd != 0 and pending[cmp_rd] == 0;
  - cmp_vld with outst_cnt == 0;
  - iss_vld && q_long with outst_cnt == MAX_OUTST and no same-cycle cmp_vld.
REQ-028 Erroneous events SHALL still obey the saturation rules (REQ-022) and clear rules (REQ-017).
REQ-029 Latency: a state change made at edge N SHALL be visible on pending, outst_cnt and stall in cycle N+1.

Reset
REQ-030 While rst is high at a clock edge, the block SHALL set pending = 0, outst_cnt = 0 and err = 0.
REQ-031 rst SHALL override every simultaneous iss_vld or cmp_vld.
REQ-032 A reset with long ops in flight SHALL discard their tracking.
REQ-033 Completions arriving after reset and before any new issue SHALL set err.

Verification
REQ-034 Load-use: issue long rd=5; next cycle query rs1=5 -> stall=1; cmp_rd=5 in a later cycle -> stall=0 in that same cycle, pending[5]=0 next cycle.
REQ-035 Structural: MAX_OUTST=2; issue long rd=3, then rd=4; query long rd=6 -> stall=1, outst_cnt=2; one cmp -> stall=0 that cycle, outst_cnt=1 next cycle.
REQ-036 x0: issue long rd=0 -> pending stays 0, outst_cnt=1; query rs1=0 -> stall=0; cmp_rd=0 -> outst_cnt=0, err=0.
REQ-037 Same-edge set/clear: pending[7]=1; issue long rd=7 with cmp_rd=7 -> pending[7]=1, outst_cnt unchanged, err=0.
REQ-038 Error and reset: cmp_rd=9 with pending[9]=0 -> err=1 next cycle and held; assert rst with 2 ops in flight -> pending=0, outst_cnt=0, err=0 next cycle.
